// File: rtl/led_seq_pkg.sv
// Shared definitions for the multi-channel LED sequencer: channel mode encodings.
package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: shadow/pending config, active config applied on tick,
// blink counter/phase and the lit decision for the current cycle.
module led_channel
  import led_seq_pkg::*;
#(
  parameter int BLINK_W  = 10,
  parameter int PWM_BITS = 8,
  parameter int ARG_W    = 10
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wr,
  input  led_mode_e           wr_mode,
  input  logic [ARG_W-1:0]    wr_arg,
  output logic                pending,
  output logic                lit
);

  led_mode_e          sh_mode;
  led_mode_e          act_mode;
  logic [ARG_W-1:0]   sh_arg;
  logic [ARG_W-1:0]   act_arg;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_last;
  logic               blink_ph;

  // A half-period of zero is treated as one tick.
  assign blink_last = (act_arg[BLINK_W-1:0] == '0) ? '0
                    : act_arg[BLINK_W-1:0] - BLINK_W'(1);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sh_mode   <= MODE_OFF;
      sh_arg    <= '0;
      pending   <= 1'b0;
      act_mode  <= MODE_OFF;
      act_arg   <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else begin
      if (tick && pending) begin
        act_mode  <= sh_mode;
        act_arg   <= sh_arg;
        pending   <= 1'b0;
        blink_cnt <= '0;
        blink_ph  <= 1'b1;
      end else if (tick && act_mode == MODE_BLINK) begin
        if (blink_cnt == blink_last) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
      // Writes are only strobed while not pending, so they never collide with an apply.
      if (wr) begin
        sh_mode <= wr_mode;
        sh_arg  <= wr_arg;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    lit = 1'b0;
    case (act_mode)
      MODE_ON:    lit = 1'b1;
      MODE_BLINK: lit = blink_ph;
      MODE_PWM:   lit = (pwm_cnt < act_arg[PWM_BITS-1:0]);
      default:    lit = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_sequencer.sv
// Multi-channel LED driver: shared prescaler and PWM counter, config write
// port with per-channel pending handshake, registered polarity-corrected pins.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int  CHANNELS   = 6,
  parameter int  TICK_DIV   = 180_000,
  parameter int  BLINK_W    = 10,
  parameter int  PWM_BITS   = 8,
  parameter int  ACTIVE_LOW = 1,
  localparam int ARG_W      = (BLINK_W > PWM_BITS) ? BLINK_W : PWM_BITS
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [ARG_W-1:0]    cfg_arg,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] lit;
  logic [CHANNELS-1:0] wr;
  logic [15:0]         pending_ext;
  logic                xfer;
  logic [CHANNELS-1:0] led_p1;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

  // Channels beyond CHANNELS read as never pending, so their writes are accepted and dropped.
  assign pending_ext = 16'(pending);
  assign cfg_ready   = !reset && !pending_ext[cfg_chan];
  assign xfer        = cfg_valid && cfg_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr[i] = xfer && (cfg_chan == 4'(i));

    led_channel #(
      .BLINK_W  (BLINK_W),
      .PWM_BITS (PWM_BITS),
      .ARG_W    (ARG_W)
    ) u_chan (
      .sys_clk (sys_clk),
      .reset   (reset),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wr      (wr[i]),
      .wr_mode (led_mode_e'(cfg_mode)),
      .wr_arg  (cfg_arg),
      .pending (pending[i]),
      .lit     (lit[i])
    );
  end

  // Stage p1: registered pins, polarity applied.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      led_p1 <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      led_p1 <= (ACTIVE_LOW != 0) ? ~lit : lit;
    end
  end

  assign led = led_p1;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a cycle-level behavioural model checked every cycle.
module tb_led_sequencer;
  import led_seq_pkg::*;

  localparam int CHANNELS   = 6;
  localparam int TICK_DIV   = 4;
  localparam int BLINK_W    = 10;
  localparam int PWM_BITS   = 8;
  localparam int ACTIVE_LOW = 1;
  localparam int ARG_W      = 10;
  localparam int PWM_PERIOD = 1 << PWM_BITS;

  logic                sys_clk   = 1'b0;
  logic                reset     = 1'b1;
  logic                cfg_valid = 1'b0;
  logic [3:0]          cfg_chan  = '0;
  logic [1:0]          cfg_mode  = '0;
  logic [ARG_W-1:0]    cfg_arg   = '0;
  logic                cfg_ready;
  logic                tick;
  logic [CHANNELS-1:0] led;

  int nvec = 0;
  int nerr = 0;

  led_sequencer #(
    .CHANNELS   (CHANNELS),
    .TICK_DIV   (TICK_DIV),
    .BLINK_W    (BLINK_W),
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_arg   (cfg_arg),
    .tick      (tick),
    .led       (led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: time since reset, ticks since each channel's apply.
  int  cyc;
  int  tcount;
  int  m_mode[CHANNELS];
  int  m_arg[CHANNELS];
  int  s_mode[CHANNELS];
  int  s_arg[CHANNELS];
  int  apply_at[CHANNELS];
  bit  m_pend[CHANNELS];
  bit  started = 1'b0;
  logic [CHANNELS-1:0] exp_led;

  function automatic bit model_lit(input int ch);
    int half;
    case (m_mode[ch])
      1: return 1'b1;
      2: begin
        half = m_arg[ch] % (1 << BLINK_W);
        if (half == 0) half = 1;
        return (((tcount - apply_at[ch]) / half) % 2) == 0;
      end
      3: return (cyc % PWM_PERIOD) < (m_arg[ch] % PWM_PERIOD);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_ready();
    int c;
    c = int'(cfg_chan);
    if (reset) return 1'b0;
    if (c >= CHANNELS) return 1'b1;
    return !m_pend[c];
  endfunction

  function automatic bit model_tick();
    return (cyc % TICK_DIV) == TICK_DIV - 1;
  endfunction

  initial begin
    logic [CHANNELS-1:0] lits;
    bit rdy;
    bit tk;
    int c;
    forever begin
      @(posedge sys_clk);
      rdy = model_ready();
      tk  = model_tick();
      for (int ch = 0; ch < CHANNELS; ch++) lits[ch] = model_lit(ch);
      if (reset) exp_led = (ACTIVE_LOW != 0) ? '1 : '0;
      else       exp_led = (ACTIVE_LOW != 0) ? ~lits : lits;
      if (reset) begin
        cyc = 0;
        tcount = 0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
          m_mode[ch] = 0; m_arg[ch] = 0; s_mode[ch] = 0; s_arg[ch] = 0;
          apply_at[ch] = 0; m_pend[ch] = 1'b0;
        end
        started = 1'b1;
      end else begin
        if (tk) begin
          tcount++;
          for (int ch = 0; ch < CHANNELS; ch++) begin
            if (m_pend[ch]) begin
              m_mode[ch] = s_mode[ch];
              m_arg[ch] = s_arg[ch];
              m_pend[ch] = 1'b0;
              apply_at[ch] = tcount;
            end
          end
        end
        c = int'(cfg_chan);
        if (cfg_valid && rdy && c < CHANNELS) begin
          s_mode[c] = int'(cfg_mode);
          s_arg[c] = int'(cfg_arg);
          m_pend[c] = 1'b1;
        end
        cyc++;
      end
      @(negedge sys_clk);
      if (started) begin
        chk("model_led", 32'(led), 32'(exp_led));
        chk("model_tick", 32'(tick), 32'(model_tick()));
        chk("model_ready", 32'(cfg_ready), 32'(model_ready()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_tick();
    int i;
    i = 0;
    do begin
      step(1);
      i++;
    end while (!tick && i < 3 * TICK_DIV);
    if (!tick) chk("tick_timeout", 32'(tick), 1);
  endtask

  task automatic cfg_write(input int ch, input int mode, input int arg);
    int i;
    i = 0;
    cfg_valid = 1'b1;
    cfg_chan  = 4'(ch);
    cfg_mode  = 2'(mode);
    cfg_arg   = ARG_W'(arg);
    while (!cfg_ready && i < 4 * TICK_DIV) begin
      step(1);
      i++;
    end
    chk("write_accept", 32'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic count_lit(input int ch, output int n);
    n = 0;
    for (int i = 0; i < PWM_PERIOD; i++) begin
      if (led[ch] == 1'b0) n++;
      step(1);
    end
  endtask

  initial begin
    int n;
    logic [11:0] pat12;
    logic [5:0]  pat6;

    reset = 1'b1;
    step(3);
    chk("reset_led", 32'(led), 32'h3F);
    chk("reset_ready", 32'(cfg_ready), 0);
    chk("reset_tick", 32'(tick), 0);
    reset = 1'b0;

    n = 0;
    do begin step(1); n++; end while (!tick && n < 10);
    chk("first_tick_edges", n, 3);
    chk("idle_ready", 32'(cfg_ready), 1);
    n = 0;
    do begin step(1); n++; end while (!tick && n < 10);
    chk("tick_period", n, 4);

    // ch2 ON; a second write is held off until the first one applies.
    step(1);
    cfg_write(2, 1, 0);
    cfg_valid = 1'b1;
    cfg_chan  = 4'd2;
    cfg_mode  = 2'd1;
    chk("ch2_pend_ready", 32'(cfg_ready), 0);
    chk("ch2_before", 32'(led[2]), 1);
    wait_tick();
    chk("ch2_tick_ready", 32'(cfg_ready), 0);
    chk("ch2_tick_led", 32'(led[2]), 1);
    step(1);
    chk("ch2_after_apply_ready", 32'(cfg_ready), 1);
    chk("ch2_reg_lag", 32'(led[2]), 1);
    step(1);
    cfg_valid = 1'b0;
    chk("ch2_lit", 32'(led[2]), 0);

    // ch0 BLINK half-period 3, then 0.
    wait_tick();
    step(1);
    cfg_write(0, 2, 3);
    wait_tick();
    for (int k = 0; k < 12; k++) begin
      wait_tick();
      pat12[k] = led[0];
    end
    chk("blink3_pattern", 32'(pat12), 32'hE38);
    step(1);
    cfg_write(0, 2, 0);
    wait_tick();
    for (int k = 0; k < 6; k++) begin
      wait_tick();
      pat6[k] = led[0];
    end
    chk("blink0_pattern", 32'(pat6), 32'h2A);

    // ch1 PWM: duty 64 given with upper arg bits set, then 0, then 255.
    step(1);
    cfg_write(1, 3, 'h340);
    wait_tick();
    step(2);
    count_lit(1, n);
    chk("pwm64_lit", n, 64);
    wait_tick();
    step(1);
    cfg_write(1, 3, 0);
    wait_tick();
    step(2);
    count_lit(1, n);
    chk("pwm0_lit", n, 0);
    wait_tick();
    step(1);
    cfg_write(1, 3, 255);
    wait_tick();
    step(2);
    count_lit(1, n);
    chk("pwm255_lit", n, 255);

    // ch3 written during a tick cycle waits for the following tick.
    wait_tick();
    cfg_valid = 1'b1;
    cfg_chan  = 4'd3;
    cfg_mode  = 2'd1;
    cfg_arg   = '0;
    chk("ch3_ready", 32'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    step(2);
    chk("ch3_not_yet", 32'(led[3]), 1);
    wait_tick();
    chk("ch3_tick", 32'(led[3]), 1);
    step(2);
    chk("ch3_applied", 32'(led[3]), 0);

    // Out-of-range channel: accepted, no effect.
    cfg_write(9, 1, 0);
    chk("chan9_ready", 32'(cfg_ready), 1);
    wait_tick();
    step(2);
    chk("chan9_unused", 32'(led[5:4]), 32'h3);
    chk("chan9_kept", 32'(led[3:2]), 32'h0);

    // Reset while ch0 blinks and ch4 is pending.
    wait_tick();
    step(1);
    cfg_write(4, 1, 0);
    reset = 1'b1;
    step(1);
    chk("reset_mid_led", 32'(led), 32'h3F);
    chk("reset_mid_ready", 32'(cfg_ready), 0);
    reset = 1'b0;
    cfg_chan = 4'd4;
    wait_tick();
    wait_tick();
    wait_tick();
    step(2);
    chk("post_reset_led", 32'(led), 32'h3F);
    chk("post_reset_ch4_ready", 32'(cfg_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
